// File: rtl/or_gate_pkg.sv
// -----------------------------------------------------------------------------
// or_gate_pkg
//   Shared defaults and helpers for the or_gate leaf cell.
//   - OR_WIDTH_DEF : default operand width
//   - OR_CNT_W_DEF : default width of the rise counter
//   - sat_inc()    : increment that sticks at a maximum instead of wrapping
// -----------------------------------------------------------------------------
package or_gate_pkg;

  localparam int OR_WIDTH_DEF = 1;
  localparam int OR_CNT_W_DEF = 8;

  // Counters up to 32 bits wide are handled; callers cast to/from their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage : or_gate_pkg

// File: rtl/or_gate_if.sv
// -----------------------------------------------------------------------------
// or_gate_if
//   Bundles the operand and observation signals of one or_gate instance.
//   master : drives operands a/b, observes every result
//   slave  : the or_gate side, consumes a/b and produces the results
//   Signals: a, b (operands), y (a|b), y_q (registered y), y_rise (bit-0 rise
//   pulse), rise_cnt (saturating rise count), any_high (sticky any-bit-high).
// -----------------------------------------------------------------------------
interface or_gate_if
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH_DEF,
  parameter int CNT_W = OR_CNT_W_DEF
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_rise;
  logic [CNT_W-1:0] rise_cnt;
  logic             any_high;

  modport master (
    output a, b,
    input  y, y_q, y_rise, rise_cnt, any_high
  );

  modport slave (
    input  a, b,
    output y, y_q, y_rise, rise_cnt, any_high
  );

endinterface : or_gate_if

// File: rtl/or_gate_mon.sv
// -----------------------------------------------------------------------------
// or_gate_mon
//   Clocked observation of the OR result, updated on the same edge as Y_q so
//   every output here lines up with the registered result.
//   clk, rst_n : clock, asynchronous active-low reset
//   y0         : bit 0 of the value Y_q is about to take (Y[0])
//   y_any      : OR-reduction of the value Y_q is about to take
//   y_rise     : one-cycle pulse when Y_q[0] goes 0->1
//   rise_cnt   : saturating count of y_rise pulses
//   any_high   : sticky, set once any Y_q bit has been 1 since reset
// -----------------------------------------------------------------------------
module or_gate_mon
  import or_gate_pkg::*;
#(
  parameter int CNT_W = OR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y0,
  input  logic             y_any,
  output logic             y_rise,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             any_high
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  // prev_q mirrors Y_q[0]; comparing it with y0 gives the edge that Y_q[0]
  // is taking at this clock, so the pulse appears together with Y_q.
  logic             prev_q,  prev_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             any_q,   any_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    prev_d = y0;
    rise_d = y0 & ~prev_q;
    cnt_d  = cnt_q;
    any_d  = any_q | y_any;
    if (rise_d) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  // NOTE: the reset branch is in the sensitivity list so rst_n clears state
  // immediately, and it is tested first so reset wins over a coincident edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their inputs from before the edge.
      prev_q <= prev_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
      any_q  <= any_d;
    end
  end

  assign y_rise   = rise_q;
  assign rise_cnt = cnt_q;
  assign any_high = any_q;

endmodule : or_gate_mon

// File: rtl/or_gate.sv
// -----------------------------------------------------------------------------
// or_gate
//   Bitwise 2-input OR with a clocked observation side.
//   clk, rst_n : clock and asynchronous active-low reset (observation only)
//   A, B       : operands, WIDTH bits
//   Y          : A | B, purely combinational, independent of clk/rst_n
//   Y_q        : Y registered on clk
//   y_rise     : one-cycle pulse when Y_q[0] goes 0->1
//   rise_cnt   : saturating count of y_rise pulses (CNT_W bits)
//   any_high   : sticky, set once any Y_q bit has been 1 since reset
// -----------------------------------------------------------------------------
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH_DEF,
  parameter int CNT_W = OR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             any_high
);

  // Continuous assignment keeps Y usable with no clock or reset connected,
  // and lets X/Z follow the normal '|' rules.
  assign Y = A | B;

  logic [WIDTH-1:0] out_q, out_d;

  always_comb begin
    out_d = Y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign Y_q = out_q;

  or_gate_mon #(
    .CNT_W (CNT_W)
  ) u_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .y0       (out_d[0]),
    .y_any    (|out_d),
    .y_rise   (y_rise),
    .rise_cnt (rise_cnt),
    .any_high (any_high)
  );

endmodule : or_gate

// File: tb/tb_or_gate.sv
// -----------------------------------------------------------------------------
// tb_or_gate
//   Bench for or_gate: a scalar instance (WIDTH=1, CNT_W=8) fed through a
//   scoreboard queue, plus a WIDTH=4 instance for the bitwise cases.
// -----------------------------------------------------------------------------
module tb_or_gate;

  logic clk;
  logic rst_n;
  logic clk_en;

  or_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  or_gate_if #(.WIDTH(4), .CNT_W(8)) bus4 ();

  or_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (bus1.a),
    .B        (bus1.b),
    .Y        (bus1.y),
    .Y_q      (bus1.y_q),
    .y_rise   (bus1.y_rise),
    .rise_cnt (bus1.rise_cnt),
    .any_high (bus1.any_high)
  );

  or_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (bus4.a),
    .B        (bus4.b),
    .Y        (bus4.y),
    .Y_q      (bus4.y_q),
    .y_rise   (bus4.y_rise),
    .rise_cnt (bus4.rise_cnt),
    .any_high (bus4.any_high)
  );

  // Clock stays undriven until the combinational-only phase is over.
  initial begin
    wait (clk_en === 1'b1);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       yq;
    logic       rise;
    logic [7:0] cnt;
    logic       any_h;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one edge after each vector is applied, the scalar instance must
  // present the queued expectation.
  initial begin
    exp_t e;
    wait (clk_en === 1'b1);
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_y_q",      32'(bus1.y_q),      32'(e.yq));
        check("sb_y_rise",   32'(bus1.y_rise),   32'(e.rise));
        check("sb_rise_cnt", 32'(bus1.rise_cnt), 32'(e.cnt));
        check("sb_any_high", 32'(bus1.any_high), 32'(e.any_h));
      end
    end
  end

  // Called 2 ns after a rising edge: apply a vector, queue what the next edge
  // must produce, and return 2 ns after that edge.
  task automatic step(input logic a, input logic b, input logic yq,
                      input logic rise, input logic [7:0] cnt, input logic any_h);
    exp_t e;
    bus1.a = a;
    bus1.b = b;
    e.yq = yq; e.rise = rise; e.cnt = cnt; e.any_h = any_h;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Reference for the long toggle run (B held 0).
  logic       m_prev;
  logic [7:0] m_cnt;
  logic       m_any;

  task automatic model_step(input logic a);
    logic rise;
    rise = a & ~m_prev;
    if (rise && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    m_any  = m_any | a;
    m_prev = a;
    step(a, 1'b0, a, rise, m_cnt, m_any);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] ab;
    logic       t1_exp [4];
    t1_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
    clk_en = 1'b0;
    bus4.a = '0;
    bus4.b = '0;

    // Truth table with clk and rst_n never driven.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      bus1.a = ab[1];
      bus1.b = ab[0];
      #1;
      check("t1_y", 32'(bus1.y), 32'(t1_exp[i]));
      #9;
    end

    // Asynchronous reset, still without a clock.
    bus1.a = 1'b0;
    bus1.b = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_y_q",      32'(bus1.y_q),      32'd0);
    check("rst_y_rise",   32'(bus1.y_rise),   32'd0);
    check("rst_rise_cnt", 32'(bus1.rise_cnt), 32'd0);
    check("rst_any_high", 32'(bus1.any_high), 32'd0);

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First edge after release, then Y held high for 10 more cycles.
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);

    // Reset mid-cycle with Y_q=1, rise_cnt=3.
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_y_q",      32'(bus1.y_q),      32'd0);
    check("mid_rst_rise_cnt", 32'(bus1.rise_cnt), 32'd0);
    check("mid_rst_any_high", 32'(bus1.any_high), 32'd0);
    check("mid_rst_y",        32'(bus1.y),        32'd1);
    bus1.a = 1'b0;
    bus1.b = 1'b1;
    #1;
    check("mid_rst_y_follow", 32'(bus1.y), 32'd1);
    @(posedge clk);
    #1;
    check("rst_holds_y_q", 32'(bus1.y_q), 32'd0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // 300 rises on A with B=0: counter must stop at 255.
    m_prev = 1'b0;
    m_cnt  = 8'd0;
    m_any  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      model_step(1'b1);
      model_step(1'b0);
    end
    check("sat_rise_cnt", 32'(bus1.rise_cnt), 32'd255);

    // Bitwise behaviour on the 4-bit instance.
    bus4.a = 4'b1010;
    bus4.b = 4'b0101;
    #1;
    check("w4_y_ones",       32'(bus4.y),   32'hF);
    check("w4_y_q_not_yet",  32'(bus4.y_q), 32'h0);
    @(posedge clk);
    #1;
    check("w4_y_q_ones",     32'(bus4.y_q),     32'hF);
    check("w4_y_rise",       32'(bus4.y_rise),  32'd1);
    check("w4_any_high",     32'(bus4.any_high), 32'd1);
    #1;
    bus4.a = 4'b0000;
    bus4.b = 4'b0000;
    #1;
    check("w4_y_zero",       32'(bus4.y),   32'h0);
    check("w4_y_q_hold",     32'(bus4.y_q), 32'hF);
    @(posedge clk);
    #1;
    check("w4_y_q_zero",     32'(bus4.y_q),     32'h0);
    check("w4_any_sticky",   32'(bus4.any_high), 32'd1);

    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_or_gate
